// File: rtl/rgb_frame_reader_pkg.sv
// ============================================================================
// rgb_frame_reader_pkg : shared state type and frame geometry constants
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package rgb_frame_reader_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } rgb_rd_state_type;

  localparam logic [17:0] RGB_BASE    = 18'd146944;
  localparam int          IMG_WIDTH   = 320;
  localparam int          IMG_HEIGHT  = 240;
  localparam int          FIFO_DEPTH  = 4;
  localparam int          TOTAL_WORDS = IMG_WIDTH * IMG_HEIGHT * 3 / 2;

  function automatic logic [17:0] last_word_addr(input logic [17:0] base, input int total);
    return base + 18'(total - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rgb_frame_reader_fifo.sv
// ============================================================================
// sync_fifo : single-clock show-ahead FIFO with occupancy count
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo
  import rgb_frame_reader_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                     i_clk,
  input  logic                     i_resetn,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  output logic                     o_full
);

  localparam int c_AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_AW:0]    r_count;
  logic             w_wr;
  logic             w_rd;

  assign w_wr    = i_push && !o_full;
  assign w_rd    = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (c_AW+1)'(DEPTH));

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/rgb_frame_reader.sv
// ============================================================================
// rgb_frame_reader : streams packed RGB words from SRAM as raster pixels
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module rgb_frame_reader
  import rgb_frame_reader_pkg::*;
#(
  parameter logic [17:0] BASE_ADDR    = RGB_BASE,
  parameter int          FRAME_WIDTH  = IMG_WIDTH,
  parameter int          FRAME_HEIGHT = IMG_HEIGHT,
  parameter int          DEPTH        = FIFO_DEPTH
) (
  input  logic        CLOCK_50_I,
  input  logic        resetn,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [17:0] SRAM_address,
  output logic        SRAM_we_n,
  input  logic [15:0] SRAM_read_data,
  output logic        pixel_valid,
  input  logic        pixel_ready,
  output logic [7:0]  pixel_R,
  output logic [7:0]  pixel_G,
  output logic [7:0]  pixel_B,
  output logic        pixel_eol,
  output logic        pixel_eof
);

  localparam int          c_WORDS     = FRAME_WIDTH * FRAME_HEIGHT * 3 / 2;
  localparam logic [17:0] c_LAST_ADDR = last_word_addr(BASE_ADDR, c_WORDS);
  localparam int          c_CW        = $clog2(DEPTH) + 1;
  localparam int          c_CRW       = c_CW + 1;
  localparam logic [15:0] c_X_LAST    = 16'(FRAME_WIDTH - 1);
  localparam logic [15:0] c_Y_LAST    = 16'(FRAME_HEIGHT - 1);

  rgb_rd_state_type r_state;
  logic [17:0]      r_addr;
  logic             r_busy;
  logic             r_done;
  logic             r_v1;
  logic             r_v2;
  logic [1:0]       r_phase;
  logic [7:0]       r_r0;
  logic [7:0]       r_g0;
  logic [7:0]       r_r1;
  logic [7:0]       r_pix_r;
  logic [7:0]       r_pix_g;
  logic [7:0]       r_pix_b;
  logic             r_pix_valid;
  logic [15:0]      r_x;
  logic [15:0]      r_y;

  logic [15:0]      w_fifo_data;
  logic [c_CW-1:0]  w_fifo_count;
  logic             w_fifo_empty;
  logic             w_fifo_full;
  logic [c_CRW-1:0] w_credits;
  logic             w_start;
  logic             w_issue;
  logic             w_accept;
  logic             w_pop;
  logic             w_eol;
  logic             w_eof;

  // Words already queued plus words still travelling through the SRAM pipeline
  assign w_credits = c_CRW'(w_fifo_count) + c_CRW'(r_v1) + c_CRW'(r_v2);
  assign w_start   = start && (r_state == S_IDLE);
  assign w_issue   = (r_state == S_FETCH) && (w_credits < c_CRW'(DEPTH));
  assign w_accept  = r_pix_valid && pixel_ready;
  assign w_pop     = !w_fifo_empty && (!r_pix_valid || pixel_ready);
  assign w_eol     = (r_x == c_X_LAST);
  assign w_eof     = w_eol && (r_y == c_Y_LAST);

  sync_fifo #(.WIDTH(16), .DEPTH(DEPTH)) u_fifo (
    .i_clk    (CLOCK_50_I),
    .i_resetn (resetn),
    .i_push   (r_v2),
    .i_data   (SRAM_read_data),
    .i_pop    (w_pop),
    .o_data   (w_fifo_data),
    .o_count  (w_fifo_count),
    .o_empty  (w_fifo_empty),
    .o_full   (w_fifo_full)
  );

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_addr  <= BASE_ADDR;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_v1    <= 1'b0;
      r_v2    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_v1   <= w_issue;
      r_v2   <= r_v1;
      case (r_state)
        S_IDLE: if (w_start) begin
          r_addr  <= BASE_ADDR;
          r_busy  <= 1'b1;
          r_state <= S_FETCH;
        end
        S_FETCH: if (w_issue) begin
          r_addr <= r_addr + 18'd1;
          if (r_addr == c_LAST_ADDR) r_state <= S_DRAIN;
        end
        S_DRAIN: if (w_accept && w_eof) begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      r_phase     <= 2'd0;
      r_r0        <= 8'd0;
      r_g0        <= 8'd0;
      r_r1        <= 8'd0;
      r_pix_r     <= 8'd0;
      r_pix_g     <= 8'd0;
      r_pix_b     <= 8'd0;
      r_pix_valid <= 1'b0;
      r_x         <= 16'd0;
      r_y         <= 16'd0;
    end else if (w_start) begin
      r_phase <= 2'd0;
      r_x     <= 16'd0;
      r_y     <= 16'd0;
    end else begin
      if (w_accept) begin
        if (w_eol) begin
          r_x <= 16'd0;
          r_y <= w_eof ? 16'd0 : r_y + 16'd1;
        end else begin
          r_x <= r_x + 16'd1;
        end
      end
      if (w_pop && (r_phase != 2'd0)) r_pix_valid <= 1'b1;
      else if (w_accept)              r_pix_valid <= 1'b0;
      // Three words carry two pixels: {R0,G0} {B0,R1} {G1,B1}
      if (w_pop) begin
        case (r_phase)
          2'd0: begin
            r_r0    <= w_fifo_data[15:8];
            r_g0    <= w_fifo_data[7:0];
            r_phase <= 2'd1;
          end
          2'd1: begin
            r_pix_r <= r_r0;
            r_pix_g <= r_g0;
            r_pix_b <= w_fifo_data[15:8];
            r_r1    <= w_fifo_data[7:0];
            r_phase <= 2'd2;
          end
          default: begin
            r_pix_r <= r_r1;
            r_pix_g <= w_fifo_data[15:8];
            r_pix_b <= w_fifo_data[7:0];
            r_phase <= 2'd0;
          end
        endcase
      end
    end
  end

  a_no_overflow: assert property (@(posedge CLOCK_50_I) disable iff (!resetn)
                                  !(r_v2 && w_fifo_full));

  assign busy         = r_busy;
  assign done         = r_done;
  assign SRAM_address = r_addr;
  assign SRAM_we_n    = 1'b1;
  assign pixel_valid  = r_pix_valid;
  assign pixel_R      = r_pix_r;
  assign pixel_G      = r_pix_g;
  assign pixel_B      = r_pix_b;
  assign pixel_eol    = r_pix_valid && w_eol;
  assign pixel_eof    = r_pix_valid && w_eof;

endmodule

`default_nettype wire

// File: tb/tb_rgb_frame_reader.sv
// ============================================================================
// tb_rgb_frame_reader : reduced-frame bench with SRAM model and pixel reference
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rgb_frame_reader;

  localparam int          W     = 16;
  localparam int          H     = 8;
  localparam int          N     = W * H;
  localparam int          WORDS = N * 3 / 2;
  // Frame placed so its last word sits at the top of the 18-bit space
  localparam logic [17:0] BASE  = 18'd261952;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        busy;
  logic        done;
  logic [17:0] SRAM_address;
  logic        SRAM_we_n;
  logic [15:0] SRAM_read_data = 16'd0;
  logic        pixel_valid;
  logic        pixel_ready;
  logic [7:0]  pixel_R;
  logic [7:0]  pixel_G;
  logic [7:0]  pixel_B;
  logic        pixel_eol;
  logic        pixel_eof;
  logic [17:0] r_addr_q = 18'd0;

  int checks = 0;
  int errors = 0;

  rgb_frame_reader #(
    .BASE_ADDR(BASE), .FRAME_WIDTH(W), .FRAME_HEIGHT(H), .DEPTH(4)
  ) dut (
    .CLOCK_50_I     (clk),
    .resetn         (resetn),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .SRAM_address   (SRAM_address),
    .SRAM_we_n      (SRAM_we_n),
    .SRAM_read_data (SRAM_read_data),
    .pixel_valid    (pixel_valid),
    .pixel_ready    (pixel_ready),
    .pixel_R        (pixel_R),
    .pixel_G        (pixel_G),
    .pixel_B        (pixel_B),
    .pixel_eol      (pixel_eol),
    .pixel_eof      (pixel_eof)
  );

  always #10 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [17:0] a);
    logic [31:0] t;
    t = {14'd0, a} * 32'd40503 + 32'h1234;
    return t[23:8];
  endfunction

  // Address registered at one edge, data driven at the next
  always @(posedge clk) begin
    r_addr_q       <= SRAM_address;
    SRAM_read_data <= mem_word(r_addr_q);
  end

  // Expected {R,G,B,eol,eof} of raster pixel p straight from the packing rule
  function automatic logic [25:0] exp_pix(input int p);
    logic [17:0] a0;
    logic [15:0] w0, w1, w2;
    logic [23:0] rgb;
    a0 = BASE + 18'(3 * (p / 2));
    w0 = mem_word(a0);
    w1 = mem_word(a0 + 18'd1);
    w2 = mem_word(a0 + 18'd2);
    if (p % 2 == 0) rgb = {w0[15:8], w0[7:0], w1[15:8]};
    else            rgb = {w1[7:0], w2[15:8], w2[7:0]};
    return {rgb, (p % W) == W - 1, p == N - 1};
  endfunction

  function automatic logic draw(input int pct);
    return int'($urandom_range(0, 99)) < pct;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_done"},  32'(done), 0);
    check({tag, "_valid"}, 32'(pixel_valid), 0);
    check({tag, "_rgb"},   {8'd0, pixel_R, pixel_G, pixel_B}, 0);
    check({tag, "_eoleof"}, {30'd0, pixel_eol, pixel_eof}, 0);
    check({tag, "_addr"},  32'(SRAM_address), 32'(BASE));
    check({tag, "_we_n"},  32'(SRAM_we_n), 1);
  endtask

  task automatic abort_frame();
    @(posedge clk); #1;
    resetn = 1'b0; start = 1'b0; pixel_ready = 1'b0;
    #1 check_reset("async_rst");
    repeat (2) begin
      @(negedge clk);
      check("rst_no_done", 32'(done), 0);
    end
    @(posedge clk); #1 resetn = 1'b1;
  endtask

  task automatic run_frame(input int pct, input int mid_start, input int abort_at);
    int n = 0, p = 0, n_first = -1, n_done = -1, issued = 0;
    bit eof_acc = 1'b0, stall = 1'b0, mid_fired = 1'b0, pulse = 1'b0, acc;
    logic [25:0] held = '0, obs;
    logic [17:0] prev_addr = BASE;
    @(posedge clk); #1 start = 1'b1; pixel_ready = draw(pct);
    @(posedge clk); #1 start = 1'b0; pixel_ready = draw(pct);
    // n counts edges after the start-sampling edge; samples taken at negedge
    while (n_done < 0 && n < WORDS * 20 + 100) begin
      @(negedge clk);
      obs = {pixel_R, pixel_G, pixel_B, pixel_eol, pixel_eof};
      if (n == 0) check("busy_after_start", 32'(busy), 1);
      check("done_timing", 32'(done), 32'(eof_acc));
      if (done) begin
        n_done = n;
        check("busy_at_done", 32'(busy), 0);
      end
      if (stall) check("stall_hold", {5'd0, pixel_valid, obs}, {5'd0, 1'b1, held});
      if (SRAM_address !== prev_addr) begin
        check("addr_step", 32'(SRAM_address), 32'(18'(prev_addr + 18'd1)));
        prev_addr = SRAM_address;
        issued++;
      end
      if (pixel_valid && n_first < 0) n_first = n;
      acc     = pixel_valid && pixel_ready;
      eof_acc = acc && (p == N - 1);
      if (acc) begin
        check("pixel", 32'(obs), 32'(exp_pix(p)));
        p++;
      end
      stall = pixel_valid && !pixel_ready;
      held  = obs;
      pulse = 1'b0;
      if (mid_start >= 0 && !mid_fired && p >= mid_start) begin
        pulse     = 1'b1;
        mid_fired = 1'b1;
      end
      if (abort_at >= 0 && p >= abort_at) begin
        abort_frame();
        return;
      end
      @(posedge clk); #1;
      n++;
      start       = pulse;
      pixel_ready = draw(pct);
    end
    check("frame_done_seen", 32'(n_done >= 0), 1);
    check("pixel_count", 32'(p), 32'(N));
    check("issue_count", 32'(issued), 32'(WORDS));
    check("final_addr", 32'(SRAM_address), 32'(18'(BASE + 18'(WORDS))));
    check("first_pixel_latency", 32'(n_first), 5);
    // Cycles from the start-high cycle through the done cycle inclusive
    if (pct >= 100)
      check("frame_time", 32'((n_done + 2 >= WORDS + 5) && (n_done + 2 <= WORDS + 7)), 1);
    repeat (3) begin
      @(negedge clk);
      check("idle_after_done", {29'd0, done, busy, pixel_valid}, 0);
    end
  endtask

  initial begin
    resetn      = 1'b0;
    start       = 1'b0;
    pixel_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("por");
    @(posedge clk); #1 resetn = 1'b1;

    run_frame(100, -1, -1);
    run_frame(30, -1, -1);
    run_frame(100, N / 2, -1);
    run_frame(100, -1, 50);
    run_frame(60, -1, -1);

    @(negedge clk);
    check("end_addr_wrapped", 32'(SRAM_address), 32'(18'(BASE + 18'(WORDS))));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
